pc_word_fetch: RTL
==================

// Module: pc_word_fetch
// PURPOSE
//  Instruction-fetch front end: the inverse of the branch shift-left-2 path. Takes a PC
//  byte address, checks it, drops the two byte-offset bits (>>2) to form the instruction
//  memory word index, and runs a req/ack read with timeout. Returns one instruction word
//  per accepted fetch, or one fault. Sits between the PC register and instruction memory.
// PARAMETERS
//  IDX_W    8   instruction memory word-index width (depth = 2**IDX_W words)
//  TIMEOUT  15  max cycles mem_req may stay high without mem_ack before abort (1..255)
// PORTS
//  clk            in   1      single clock, rising edge
//  reset          in   1      asynchronous, active-high reset
//  pc_in          in   32     PC byte address to fetch
//  pc_load        in   1      fetch request; sampled only when fetch_busy=0
//  fetch_busy     out  1      1 while a memory read is outstanding
//  mem_req        out  1      read request to instruction memory, held until ack/abort
//  mem_word_addr  out  IDX_W  word index = pc_in[IDX_W+1:2], stable while mem_req=1
//  mem_ack        in   1      memory read done; mem_rdata valid in the same cycle
//  mem_rdata      in   32     memory read data
//  instr          out  32     fetched instruction word
//  instr_pc       out  32     byte address that instr belongs to
//  instr_valid    out  1      1-cycle pulse: instr/instr_pc updated
//  fault          out  1      1-cycle pulse: fetch rejected or aborted
//  fault_code     out  2      01 misaligned, 10 out of range, 11 timeout; held until next fault
// BEHAVIOUR
//  - Reset (async): state IDLE; mem_req, fetch_busy, instr_valid, fault = 0; instr, instr_pc,
//    mem_word_addr = 0; fault_code = 00; timeout counter = 0. Reset mid-read drops mem_req
//    immediately and discards the read; a later mem_ack is ignored.
//  - FSM: IDLE, WAIT. fetch_busy = (state==WAIT); mem_req = (state==WAIT).
//  - IDLE, pc_load=1, edge: checks in priority order:
//    pc_in[1:0]!=0 -> fault=1, fault_code=01, stay IDLE;
//    else pc_in[31:IDX_W+2]!=0 -> fault=1, fault_code=10, stay IDLE;
//    else mem_word_addr<=pc_in[IDX_W+1:2], instr_pc<=pc_in, counter<=0, go WAIT.
//    Both checks fail -> code 01 only. mem_ack in IDLE is ignored.
//  - WAIT, edge with mem_ack=1: instr<=mem_rdata, instr_valid=1 next cycle, go IDLE.
//    New pc_load is accepted from the first IDLE cycle: back-to-back throughput is one
//    fetch per 2 cycles with zero-wait memory (req cycle + idle cycle).
//  - WAIT, mem_ack=0: counter++; ack absent on edge where counter==TIMEOUT-1 ->
//    fault=1, fault_code=11, go IDLE (mem_req high exactly TIMEOUT cycles). Ack arriving
//    on that same edge wins: normal completion, no fault.
//  - pc_load while fetch_busy=1: ignored, no queuing, no fault.
//  - instr_valid and fault are never high in the same cycle; instr/instr_pc hold between
//    fetches; faults never change instr/instr_pc.
//  - Counter width ceil(log2(TIMEOUT+1)); no wrap reachable.
// TESTING
//  - Aligned fetch: pc_in=0x0000_0010, pc_load; mem_ack on 3rd WAIT cycle, rdata=0x2008_0005
//    -> mem_word_addr=0x04, instr=0x2008_0005, instr_pc=0x10, instr_valid one cycle.
//  - Misaligned: pc_in=0x0000_0006 -> fault pulse, fault_code=01, mem_req never rises.
//  - Range (IDX_W=8): pc_in=0x0000_0400 -> fault_code=10; pc_in=0x0000_03FC -> addr 0xFF ok.
//  - Timeout: no ack, TIMEOUT=15 -> mem_req high 15 cycles, fault_code=11; ack on the
//    15th cycle instead -> instr_valid, no fault.
//  - pc_load=0x20 during WAIT of fetch 0x10 -> ignored; only instr_pc=0x10 returned.
//  - Reset asserted mid-WAIT -> mem_req/fetch_busy low same cycle; late ack gives no pulse.

Source files
------------

// File: rtl/pc_word_fetch.sv
// Instruction-fetch front end: validates a PC byte address, converts it to a word index
// and runs a single outstanding req/ack memory read with a timeout abort.
module pc_word_fetch #(
  parameter int unsigned IDX_W   = 8,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      pc_in,
  input  logic             pc_load,
  output logic             fetch_busy,
  output logic             mem_req,
  output logic [IDX_W-1:0] mem_word_addr,
  input  logic             mem_ack,
  input  logic [31:0]      mem_rdata,
  output logic [31:0]      instr,
  output logic [31:0]      instr_pc,
  output logic             instr_valid,
  output logic             fault,
  output logic [1:0]       fault_code
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] CODE_MISALIGNED = 2'b01;
  localparam logic [1:0] CODE_RANGE      = 2'b10;
  localparam logic [1:0] CODE_TIMEOUT    = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;

  // Request and busy come straight off the state flop so reset drops them at once.
  assign mem_req    = (state == WAIT);
  assign fetch_busy = (state == WAIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      mem_word_addr <= '0;
      instr         <= '0;
      instr_pc      <= '0;
      instr_valid   <= 1'b0;
      fault         <= 1'b0;
      fault_code    <= 2'b00;
    end else begin
      instr_valid <= 1'b0;
      fault       <= 1'b0;
      case (state)
        IDLE: begin
          if (pc_load) begin
            if (pc_in[1:0] != 2'b00) begin
              fault      <= 1'b1;
              fault_code <= CODE_MISALIGNED;
            end else if (pc_in[31:IDX_W+2] != '0) begin
              fault      <= 1'b1;
              fault_code <= CODE_RANGE;
            end else begin
              mem_word_addr <= pc_in[IDX_W+1:2];
              instr_pc      <= pc_in;
              wait_cnt      <= '0;
              state         <= WAIT;
            end
          end
        end
        WAIT: begin
          // An ack on the final allowed cycle still completes normally.
          if (mem_ack) begin
            instr       <= mem_rdata;
            instr_valid <= 1'b1;
            state       <= IDLE;
          end else if (wait_cnt == CNT_LAST) begin
            fault      <= 1'b1;
            fault_code <= CODE_TIMEOUT;
            state      <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
